// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver with a first-word-fall-through byte FIFO.
// The FIFO is drained by dma_rx.
//
// Ports:
//   Clk        system clock (rising edge)
//   Rst_n      asynchronous active-low reset
//   RXD        serial input, idle high, asynchronous to Clk
//   Data_Read  pop request, one byte per cycle while high
//   Data_Out   FIFO head byte, valid while Empty=0
//   Empty      FIFO holds no entries
//   Full       FIFO holds FIFO_DEPTH entries
//   Frame_err  one-cycle pulse when a stop bit is sampled low
//   Overrun    one-cycle pulse when a received byte is dropped on a full FIFO
module uart_rx_fifo #(
  parameter int unsigned FREQ_CLK   = 100000000,
  parameter int unsigned TX_SPEED   = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       RXD,
  input  logic       Data_Read,
  output logic [7:0] Data_Out,
  output logic       Empty,
  output logic       Full,
  output logic       Frame_err,
  output logic       Overrun
);

  localparam int unsigned BIT_CYCLES = FREQ_CLK / TX_SPEED;
  localparam int unsigned HALF_BIT   = BIT_CYCLES / 2;
  localparam int unsigned CW         = $clog2(BIT_CYCLES + 1);
  localparam int unsigned AW         = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Synchroniser and edge detection
  logic          r_sync1;
  logic          r_sync2;
  logic          r_rxd_prev;
  logic [1:0]    r_vld;
  logic          r_armed;
  logic          w_fall;

  // Receiver FSM
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_push;
  logic [7:0]    r_push_data;
  logic          r_frame_err;

  // FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overrun;
  logic          w_pop;
  logic          w_push_ok;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rxd_prev <= 1'b1;
      r_vld      <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_sync1    <= RXD;
      r_sync2    <= r_sync1;
      r_rxd_prev <= r_sync2;
      r_vld      <= {r_vld[0], 1'b1};
      // Only arm once the chain carries a real post-reset sample that is high,
      // so a line held low across reset release is not taken as a start bit.
      if (r_vld[1] && r_sync2)
        r_armed <= 1'b1;
    end
  end

  assign w_fall = r_armed & r_rxd_prev & ~r_sync2;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_sync2 ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit_idx == 3'd7)
              r_state <= S_STOP;
            else
              r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt       <= '0;
            r_push      <= r_sync2;
            r_push_data <= r_shift;
            r_frame_err <= ~r_sync2;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign Empty     = (r_count == '0);
  assign Full      = (r_count == DEPTH_C);
  assign w_pop     = Data_Read & ~Empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok = r_push & (~Full | Data_Read);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= r_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overrun <= r_push & ~w_push_ok;
    end
  end

  assign Data_Out  = r_mem[r_rd_ptr];
  assign Frame_err = r_frame_err;
  assign Overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo, run with a short bit period (16 clocks per bit).
module tb_uart_rx_fifo;

  localparam int unsigned FREQ  = 1600000;
  localparam int unsigned SPEED = 100000;
  localparam int          BIT   = 16;
  localparam int          HALF  = 8;
  localparam int          LAT   = 2 + 1 + HALF + 9 * BIT + 1;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       RXD = 1'b1;
  logic       Data_Read = 1'b0;
  logic [7:0] Data_Out;
  logic       Empty;
  logic       Full;
  logic       Frame_err;
  logic       Overrun;

  int         checks = 0;
  int         errors = 0;
  int         fe_cycles = 0;
  int         ov_cycles = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(
    .FREQ_CLK  (FREQ),
    .TX_SPEED  (SPEED),
    .FIFO_DEPTH(16)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .RXD      (RXD),
    .Data_Read(Data_Read),
    .Data_Out (Data_Out),
    .Empty    (Empty),
    .Full     (Full),
    .Frame_err(Frame_err),
    .Overrun  (Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted pop is compared against the queue head.
  always @(negedge Clk) begin
    if (Frame_err) fe_cycles++;
    if (Overrun) ov_cycles++;
    if (Rst_n && Data_Read && !Empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=%02h required=no_data", Data_Out);
      end else begin
        check("pop_data", {24'd0, Data_Out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v, input bit expect_push);
    if (expect_push) exp_q.push_back(b);
    RXD = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      cyc(BIT);
    end
    RXD = stop_v;
    cyc(BIT);
    RXD = 1'b1;
  endtask

  task automatic pop1();
    Data_Read = 1'b1;
    cyc(1);
    Data_Read = 1'b0;
    cyc(1);
  endtask

  initial begin
    int lat;
    @(posedge Clk);
    #1;
    // Reset with RXD toggling
    for (int i = 0; i < 10; i++) begin
      RXD = (i % 2 == 0) ? 1'b0 : 1'b1;
      cyc(1);
    end
    check("rst_empty", Empty, 1);
    check("rst_full", Full, 0);
    check("rst_data", Data_Out, 0);
    check("rst_frame_err", Frame_err, 0);
    check("rst_overrun", Overrun, 0);
    RXD = 1'b1;
    cyc(2);
    Rst_n = 1'b1;
    cyc(20);
    check("post_rst_empty", Empty, 1);

    // Single byte with latency
    lat = 0;
    fork
      send(8'h77, 1'b1, 1'b1);
      begin
        while (Empty && lat < LAT + 40) begin
          @(posedge Clk);
          #1;
          lat++;
        end
      end
    join
    check("latency_window", ((lat >= LAT - 1) && (lat <= LAT + 1)) ? 1 : 0, 1);
    if (lat < LAT - 1 || lat > LAT + 1) $display("FAIL latency actual=%0d required=%0d", lat, LAT);
    check("single_data", Data_Out, 8'h77);
    pop1();
    check("single_empty_after_pop", Empty, 1);

    // Back-to-back ordering
    send(8'hAA, 1'b1, 1'b1);
    send(8'h03, 1'b1, 1'b1);
    send(8'hCC, 1'b1, 1'b1);
    cyc(5);
    check("order_not_empty", Empty, 0);
    pop1();
    pop1();
    pop1();
    check("order_empty", Empty, 1);
    check("order_no_ferr", fe_cycles, 0);

    // Start-bit glitch
    RXD = 1'b0;
    cyc(5);
    RXD = 1'b1;
    cyc(200);
    check("glitch_empty", Empty, 1);
    check("glitch_no_ferr", fe_cycles, 0);

    // Stop bit low
    send(8'h55, 1'b0, 1'b0);
    cyc(20);
    check("ferr_one_cycle", fe_cycles, 1);
    check("ferr_empty", Empty, 1);

    // Break: line held low well past one frame
    RXD = 1'b0;
    cyc(BIT * 30);
    RXD = 1'b1;
    cyc(BIT * 2);
    check("break_single_ferr", fe_cycles, 2);
    check("break_empty", Empty, 1);

    // Overflow
    for (int i = 0; i < 17; i++) begin
      send(8'(i), 1'b1, i < 16);
      if (i == 14) check("ovf_not_full_15", Full, 0);
      if (i == 15) begin
        check("ovf_full_16", Full, 1);
        check("ovf_no_overrun_16", ov_cycles, 0);
      end
    end
    cyc(4);
    check("ovf_overrun_once", ov_cycles, 1);
    check("ovf_still_full", Full, 1);
    check("ovf_no_ferr", fe_cycles, 2);

    // Pop aligned with the push while full
    fork
      send(8'h11, 1'b1, 1'b1);
      begin
        cyc(LAT - 1);
        Data_Read = 1'b1;
        cyc(1);
        Data_Read = 1'b0;
      end
    join
    cyc(4);
    check("popush_full", Full, 1);
    check("popush_no_overrun", ov_cycles, 1);

    // Drain with Data_Read held longer than the fill level
    Data_Read = 1'b1;
    cyc(18);
    Data_Read = 1'b0;
    cyc(1);
    check("drain_empty", Empty, 1);
    check("drain_not_full", Full, 0);
    check("drain_queue_done", exp_q.size(), 0);

    // Reset mid-frame with bytes buffered, released with RXD low
    send(8'hA1, 1'b1, 1'b1);
    send(8'h5E, 1'b1, 1'b1);
    cyc(5);
    check("mid_buffered", Empty, 0);
    RXD = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      RXD = (i % 2 == 0) ? 1'b1 : 1'b0;
      cyc(BIT);
    end
    RXD = 1'b0;
    Rst_n = 1'b0;
    #1;
    check("mid_rst_empty", Empty, 1);
    check("mid_rst_full", Full, 0);
    check("mid_rst_data", Data_Out, 0);
    exp_q.delete();
    cyc(5);
    Rst_n = 1'b1;
    cyc(50);
    RXD = 1'b1;
    cyc(BIT * 3);
    check("rel_low_no_ferr", fe_cycles, 2);
    check("rel_low_empty", Empty, 1);
    send(8'h3C, 1'b1, 1'b1);
    cyc(5);
    check("after_rst_not_empty", Empty, 0);
    check("after_rst_data", Data_Out, 8'h3C);
    pop1();
    check("after_rst_empty", Empty, 1);
    check("final_queue_done", exp_q.size(), 0);
    check("final_overrun_count", ov_cycles, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
